// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master for a single-port on-chip RAM with a fixed 1-cycle read
// latency. It reads a contiguous word range and emits it as one Avalon-ST packet.
// Reads are issued only when the output FIFO has a guaranteed slot for the
// returning word, so the memory never has to stall.
//
// Stream handshake: a word transfers on any rising edge where src_valid and
// src_ready are both high. Once src_valid is high, src_valid, src_data, src_sop
// and src_eop hold their values until that transfer happens. src_ready has a
// ready latency of 0.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop,
  output logic [1:0]          dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Longest legal command is one full sweep of the address space.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remaining;
  logic                first_q;      // next issued word is index 0

  logic                inflight;     // a read was issued last cycle
  logic                inflight_sop;
  logic                inflight_eop;

  // FIFO entries are {eop, sop, data}.
  logic [DATA_W+1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_W+1:0]   head;

  logic                pop;
  logic                issue;
  logic [CNT_W:0]      space;

  assign head      = fifo_mem[rd_ptr];
  assign src_valid = (fifo_count != '0);
  assign src_data  = head[DATA_W-1:0];
  assign src_sop   = src_valid & head[DATA_W];
  assign src_eop   = src_valid & head[DATA_W+1];
  assign pop       = src_valid & src_ready;

  // Free slots counting the word already in flight and the slot freed by a pop
  // in this same cycle; never negative because credit is never over-spent.
  assign space = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, fifo_count}
               - {{CNT_W{1'b0}}, inflight} + {{CNT_W{1'b0}}, pop};

  assign issue = (state == ISSUE) && (remaining != '0) && (space != '0);

  assign mem_chipselect = issue;
  assign mem_address    = addr_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign dbg_state      = state;

  // Command FSM: accept, issue reads under credit, wait for the eop hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      first_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            remaining <= (word_count > MAX_LEN) ? MAX_LEN : word_count;
            first_q   <= 1'b1;
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            first_q   <= 1'b0;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The eop word is the last one issued, so its hand-off means
          // nothing is left in flight or in the FIFO.
          if (pop && src_eop) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read issued last cycle together with its packet markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      inflight     <= issue;
      inflight_sop <= issue & first_q;
      inflight_eop <= issue & (remaining == LEN_W'(1));
    end
  end

  // FIFO storage: returning read data is written the cycle after issue.
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= {inflight_eop, inflight_sop, mem_readdata};
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (inflight) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_stream_reader.md
Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master that drains a contiguous word range from the 64K x 32 single-port on-chip memory slave and emits it as an Avalon-ST packet.
- Sits directly upstream of the memory slave's s1 port; its stream output feeds the NovaCORE datapath.
- Exploits the slave's fixed 1-cycle read latency (unregistered q) and never stalls the memory.
- A small credit-checked FIFO absorbs sink backpressure.

Parameters:
- ADDR_W, 16, word-address width; matches slave widthad.
- DATA_W, 32, data width; matches slave width.
- LEN_W, 17, width of word_count; allows a 65536-word full sweep.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address.
- word_count  in  LEN_W  number of words to read; 0 is legal.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of command.
- mem_address  out  ADDR_W  to slave address.
- mem_chipselect  out  1  read-issue qualifier.
- mem_write  out  1  tied 0.
- mem_byteenable  out  DATA_W/8  tied all-ones.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  slave readdata; valid the cycle after issue.
- src_data  out  DATA_W  stream data (FIFO head).
- src_valid  out  1  stream valid.
- src_ready  in  1  sink ready; ready latency 0.
- src_sop  out  1  high with the first word of the packet.
- src_eop  out  1  high with the last word of the packet.

Behaviour:
- Reset values: busy, done, mem_chipselect, src_valid, src_sop, src_eop all 0; mem_address 0. FIFO empty, in-flight flag 0, state IDLE.
- Reset mid-command aborts immediately: FIFO flushed, in-flight data discarded, no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on start=1 latch base_addr into addr_q and word_count into remaining and total. If word_count=0, pulse done next cycle and stay IDLE. Otherwise go to ISSUE.
  - ISSUE: a read issues in any cycle where remaining>0 and fifo_count + inflight + 1 <= FIFO_DEPTH. Issue means mem_chipselect=1 with mem_address=addr_q. Each issue increments addr_q and decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until FIFO empty and inflight=0 after the last word is accepted. Then pulse done, drop busy and return to IDLE.
- Credit counting must include the same-cycle pop: space = FIFO_DEPTH - fifo_count - inflight + (src_valid & src_ready).
- Read capture: inflight is set on an issue cycle and cleared the next cycle. mem_readdata is written into the FIFO at the edge ending the cycle after issue. No other condition gates the write.
- Latency: start high in cycle 0; first mem_chipselect in cycle 1; data captured at end of cycle 2; src_valid first high in cycle 3.
- Throughput: 1 word/cycle sustained while src_ready=1.
- Stream rules:
  - src_data/src_sop/src_eop are stable while src_valid=1 and src_ready=0.
  - src_sop is on the word with index 0; src_eop is on index total-1.
  - Both are high on a 1-word packet.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF is followed by 0x0000.
- word_count values greater than 65536 are clamped to 65536.
- Simultaneous FIFO push and pop keeps fifo_count unchanged. FIFO overflow is impossible by credit; a bench assertion flags it.
- start while busy is ignored, with no side effects.
- done timing: done pulses the cycle after the eop word handshake. start is accepted again in that same done cycle.

Test Plan:
- reset, start base=0x0010 count=4, src_ready=1 -> chipselect cycles 1-4 addr 0x10..0x13; src_valid cycles 3-6 with mem[0x10..0x13]; sop cycle 3, eop cycle 6; done cycle 7.
- count=0 -> no chipselect, no src_valid, done exactly 1 cycle after start, busy stays 0.
- base=0xFFFE count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order, data matches.
- count=16, src_ready held 0 from cycle 2 -> at most FIFO_DEPTH issues, chipselect then stops; release ready -> all 16 words delivered in order, none lost or duplicated.
- count=32, src_ready random 50% -> scoreboard exact order; sop/eop once each; data stable under backpressure.
- reset asserted mid-ISSUE at word 5 of 20 -> next cycle all outputs at reset values; a new start count=2 delivers a clean 2-word packet.
